vga_sync_detect: RTL and testbench

- Receive-side counterpart of our VGA sync generator.
- Takes positive-polarity hsync/vsync, which may come from an external source or loop back from our own generator. Measures line period, hsync width, frame height and vsync width.
- Regenerates position counters aligned to the sync rising edges.
- Asserts `locked` once timing is stable for a programmable number of frames. Used for mode detection and for genlocking downstream pixel logic.

---
 rtl/vga_sync_detect.sv | 185 ++++++++++++++++++
 tb/tb_vga_sync_detect.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_detect.sv
// vga_sync_detect: measures incoming positive-polarity hsync/vsync timing, regenerates
// position counters aligned to the sync rising edges, and reports lock once the timing
// has been stable for LOCK_FRAMES consecutive frames.
//
// Ports:
//   clk, reset        - pixel clock, asynchronous active-high reset
//   hsync_in/vsync_in - raw sync inputs (asynchronous to clk)
//   hpos/vpos         - clocks since last hsync rise / lines since last vsync rise
//   h_total/h_sync_w  - last measured line period / hsync width (clocks)
//   v_total/v_sync_w  - last measured frame height / vsync width (lines)
//   locked            - timing stable
//   mode_change       - one-clock pulse when lock is lost

module vga_sync_detect #(
  parameter int unsigned HW          = 11,
  parameter int unsigned VW          = 11,
  parameter int unsigned LOCK_FRAMES = 3,
  parameter int unsigned H_TOL       = 1,
  parameter int unsigned H_TIMEOUT   = 2047
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          hsync_in,
  input  logic          vsync_in,
  output logic [HW-1:0] hpos,
  output logic [VW-1:0] vpos,
  output logic [HW-1:0] h_total,
  output logic [HW-1:0] h_sync_w,
  output logic [VW-1:0] v_total,
  output logic [VW-1:0] v_sync_w,
  output logic          locked,
  output logic          mode_change
);

  typedef enum logic [1:0] {StSearch, StAcquire, StLocked} state_e;

  localparam logic [HW-1:0] HMax       = '1;
  localparam logic [VW-1:0] VMax       = '1;
  localparam logic [HW-1:0] HTol       = HW'(H_TOL);
  localparam logic [HW-1:0] HTimeout   = HW'(H_TIMEOUT);
  localparam logic [3:0]    LockFrames = 4'(LOCK_FRAMES);

  // [0],[1] form the synchronizer, [2] is the delay flop for edge detection.
  logic [2:0]    h_sync_q, h_sync_d, v_sync_q, v_sync_d;
  logic [HW-1:0] hcnt_q, hcnt_d, h_total_q, h_total_d, h_sync_w_q, h_sync_w_d;
  logic [VW-1:0] vcnt_q, vcnt_d, v_total_q, v_total_d, v_sync_w_q, v_sync_w_d;
  logic [HW-1:0] ref_h_q, ref_h_d;
  logic [VW-1:0] ref_v_q, ref_v_d;
  logic          ref_ok_q, ref_ok_d;
  logic [3:0]    match_q, match_d;
  logic          bad_q, bad_d;
  state_e        state_q, state_d;
  logic          locked_q, locked_d, mode_change_q, mode_change_d;

  logic          h_rise, h_fall, v_rise, v_fall;
  logic [HW-1:0] h_len, h_dev;
  logic          h_bad, bad_now, timeout;

  assign h_rise = h_sync_q[1] & ~h_sync_q[2];
  assign h_fall = ~h_sync_q[1] & h_sync_q[2];
  assign v_rise = v_sync_q[1] & ~v_sync_q[2];
  assign v_fall = ~v_sync_q[1] & v_sync_q[2];

  always_comb begin
    h_sync_d = {h_sync_q[1:0], hsync_in};
    v_sync_d = {v_sync_q[1:0], vsync_in};

    // Measurements
    h_len      = hcnt_q + 1'b1;
    hcnt_d     = h_rise ? '0 : ((hcnt_q == HMax) ? HMax : hcnt_q + 1'b1);
    h_total_d  = h_rise ? h_len : h_total_q;
    h_sync_w_d = h_fall ? h_len : h_sync_w_q;

    // A coincident h_rise is not counted: the new frame starts at zero.
    vcnt_d = vcnt_q;
    if (v_rise) begin
      vcnt_d = '0;
    end else if (h_rise && vcnt_q != VMax) begin
      vcnt_d = vcnt_q + 1'b1;
    end
    v_total_d  = v_rise ? vcnt_q : v_total_q;
    v_sync_w_d = v_fall ? vcnt_q : v_sync_w_q;

    // Line-period deviation against the reference
    h_dev   = (h_len >= ref_h_q) ? (h_len - ref_h_q) : (ref_h_q - h_len);
    h_bad   = h_rise && (h_dev > HTol);
    bad_now = bad_q | h_bad;
    timeout = (hcnt_d >= HTimeout);

    // Lock FSM
    state_d  = state_q;
    ref_h_d  = ref_h_q;
    ref_v_d  = ref_v_q;
    ref_ok_d = ref_ok_q;
    match_d  = match_q;
    bad_d    = bad_now;
    if (v_rise) begin
      bad_d = 1'b0;
      unique case (state_q)
        StSearch: begin
          // The frame ending here is partial, so ref_v is taken at the next v_rise.
          state_d  = StAcquire;
          ref_h_d  = h_total_q;
          ref_ok_d = 1'b0;
          match_d  = '0;
        end
        StAcquire: begin
          if (ref_ok_q && !bad_now && vcnt_q == ref_v_q) begin
            match_d = match_q + 4'd1;
            if (match_q + 4'd1 == LockFrames) begin
              state_d = StLocked;
            end
          end else begin
            ref_h_d  = h_total_q;
            ref_v_d  = vcnt_q;
            ref_ok_d = 1'b1;
            match_d  = '0;
          end
        end
        StLocked: begin
          if (bad_now || vcnt_q != ref_v_q) begin
            state_d = StAcquire;
            match_d = '0;
          end
        end
        default: state_d = StSearch;
      endcase
    end
    // Stays forced while hcnt is saturated, so SEARCH holds until hsync resumes.
    if (timeout) begin
      state_d = StSearch;
    end

    locked_d      = (state_q == StLocked) && (state_d == StLocked);
    mode_change_d = (state_q == StLocked) && (state_d != StLocked);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_sync_q      <= '0;
      v_sync_q      <= '0;
      hcnt_q        <= '0;
      h_total_q     <= '0;
      h_sync_w_q    <= '0;
      vcnt_q        <= '0;
      v_total_q     <= '0;
      v_sync_w_q    <= '0;
      ref_h_q       <= '0;
      ref_v_q       <= '0;
      ref_ok_q      <= 1'b0;
      match_q       <= '0;
      bad_q         <= 1'b0;
      state_q       <= StSearch;
      locked_q      <= 1'b0;
      mode_change_q <= 1'b0;
    end else begin
      h_sync_q      <= h_sync_d;
      v_sync_q      <= v_sync_d;
      hcnt_q        <= hcnt_d;
      h_total_q     <= h_total_d;
      h_sync_w_q    <= h_sync_w_d;
      vcnt_q        <= vcnt_d;
      v_total_q     <= v_total_d;
      v_sync_w_q    <= v_sync_w_d;
      ref_h_q       <= ref_h_d;
      ref_v_q       <= ref_v_d;
      ref_ok_q      <= ref_ok_d;
      match_q       <= match_d;
      bad_q         <= bad_d;
      state_q       <= state_d;
      locked_q      <= locked_d;
      mode_change_q <= mode_change_d;
    end
  end

  assign hpos        = hcnt_q;
  assign vpos        = vcnt_q;
  assign h_total     = h_total_q;
  assign h_sync_w    = h_sync_w_q;
  assign v_total     = v_total_q;
  assign v_sync_w    = v_sync_w_q;
  assign locked      = locked_q;
  assign mode_change = mode_change_q;

endmodule

// File: tb/tb_vga_sync_detect.sv
// Directed bench for vga_sync_detect. Frame heights are scaled down (6-8 lines) to keep
// the run short; line lengths and sync widths follow the nominal modes.

module tb_vga_sync_detect;

  logic        clk = 1'b0;
  logic        reset;
  logic        hsync_in, vsync_in;
  logic [10:0] hpos, vpos, h_total, h_sync_w, v_total, v_sync_w;
  logic        locked, mode_change;

  int n_tests = 0;
  int n_fail  = 0;

  vga_sync_detect #(
    .HW(11), .VW(11), .LOCK_FRAMES(3), .H_TOL(1), .H_TIMEOUT(2047)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .hsync_in    (hsync_in),
    .vsync_in    (vsync_in),
    .hpos        (hpos),
    .vpos        (vpos),
    .h_total     (h_total),
    .h_sync_w    (h_sync_w),
    .v_total     (v_total),
    .v_sync_w    (v_sync_w),
    .locked      (locked),
    .mode_change (mode_change)
  );

  always #5 clk = ~clk;

  // Sync source configuration, read live by the generator.
  int g_len = 410, g_hs = 34, g_lines = 6, g_vs = 5, g_off = 100, g_stretch = 0;
  bit g_hold = 1'b0;

  initial begin
    int line, px, cur_len;
    line = 0; px = 0; cur_len = 0;
    hsync_in = 1'b0;
    vsync_in = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (g_hold) begin
        hsync_in = 1'b0;
        vsync_in = 1'b0;
        line = 0;
        px = 0;
      end else begin
        if (px == 0) begin
          cur_len   = g_len + g_stretch;
          g_stretch = 0;
        end
        hsync_in = (px < g_hs);
        vsync_in = ((line > 0) || (px >= g_off)) &&
                   ((line < g_vs) || ((line == g_vs) && (px < g_off)));
        px++;
        if (px >= cur_len) begin
          px = 0;
          line++;
          if (line >= g_lines) line = 0;
        end
      end
    end
  end

  // Counts vsync strobes (vpos returning to 0) and mode_change cycles.
  int          vr_cnt = 0;
  int          mc_cnt = 0;
  logic [10:0] vpos_prev = '0;
  always @(posedge clk) begin
    #1;
    if (reset) begin
      vpos_prev = '0;
    end else begin
      if (vpos_prev != 0 && vpos == 0) vr_cnt++;
      if (mode_change) mc_cnt++;
      vpos_prev = vpos;
    end
  end

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic wait_vr(input int n, input int budget);
    int target, c;
    target = vr_cnt + n;
    c = 0;
    while (vr_cnt < target && c < budget) begin
      @(negedge clk);
      c++;
    end
    check_eq("vrise_wait", longint'(vr_cnt >= target), 1);
  endtask

  task automatic wait_pos(input int vp, input int hp, input int budget);
    int c;
    c = 0;
    while (!((vpos == vp || vp < 0) && (hpos == hp || hp < 0)) && c < budget) begin
      @(negedge clk);
      c++;
    end
    check_eq("pos_wait", longint'(c < budget), 1);
  endtask

  initial begin
    int mc0;
    reset = 1'b1;
    #2;
    check_eq("rst_hpos", hpos, 0);
    check_eq("rst_vpos", vpos, 0);
    check_eq("rst_h_total", h_total, 0);
    check_eq("rst_h_sync_w", h_sync_w, 0);
    check_eq("rst_v_total", v_total, 0);
    check_eq("rst_v_sync_w", v_sync_w, 0);
    check_eq("rst_locked", locked, 0);
    check_eq("rst_mode_change", mode_change, 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Initial lock: SEARCH->ACQUIRE, ref_v load, then 3 matching frames.
    wait_vr(4, 20000);
    repeat (3) @(negedge clk);
    check_eq("lock_not_yet", locked, 0);
    wait_vr(1, 5000);
    repeat (3) @(negedge clk);
    check_eq("lock_410", locked, 1);
    check_eq("h_total_410", h_total, 410);
    check_eq("h_sync_w_34", h_sync_w, 34);
    check_eq("v_total_6", v_total, 6);
    check_eq("v_sync_w_5", v_sync_w, 5);
    wait_pos(-1, 409, 1000);
    @(negedge clk);
    check_eq("hpos_wrap", hpos, 0);

    // One 411-clock line is within tolerance.
    mc0 = mc_cnt;
    wait_pos(2, -1, 5000);
    g_stretch = 1;
    wait_vr(2, 8000);
    repeat (3) @(negedge clk);
    check_eq("tol_411_locked", locked, 1);
    check_eq("tol_411_no_mc", mc_cnt - mc0, 0);

    // One 412-clock line breaks lock at the next vsync, regained after 3 good frames.
    mc0 = mc_cnt;
    wait_pos(2, -1, 5000);
    g_stretch = 2;
    wait_vr(1, 5000);
    repeat (3) @(negedge clk);
    check_eq("bad_412_unlock", locked, 0);
    check_eq("bad_412_mc", mc_cnt - mc0, 1);
    wait_vr(2, 8000);
    repeat (3) @(negedge clk);
    check_eq("bad_412_acq", locked, 0);
    wait_vr(1, 5000);
    repeat (3) @(negedge clk);
    check_eq("bad_412_relock", locked, 1);

    // Mode switch mid-frame to 550-clock lines.
    mc0 = mc_cnt;
    wait_pos(2, -1, 5000);
    g_len = 550;
    g_hs  = 13;
    wait_vr(1, 5000);
    repeat (3) @(negedge clk);
    check_eq("switch_unlock", locked, 0);
    check_eq("switch_mc", mc_cnt - mc0, 1);
    wait_vr(3, 12000);
    repeat (3) @(negedge clk);
    check_eq("switch_acq", locked, 0);
    wait_vr(1, 5000);
    repeat (3) @(negedge clk);
    check_eq("switch_relock", locked, 1);
    check_eq("h_total_550", h_total, 550);
    check_eq("h_sync_w_13", h_sync_w, 13);
    check_eq("v_total_550", v_total, 6);

    // hsync timeout: 2047 clocks after the last strobe lock drops.
    wait_pos(-1, 5, 1000);
    g_hold = 1'b1;
    wait_pos(-1, 2046, 3000);
    check_eq("to_pre_locked", locked, 1);
    check_eq("to_pre_mc", mode_change, 0);
    @(negedge clk);
    check_eq("to_hpos", hpos, 2047);
    check_eq("to_locked", locked, 0);
    check_eq("to_mc", mode_change, 1);
    @(negedge clk);
    check_eq("to_mc_pulse", mode_change, 0);
    check_eq("to_hpos_sat", hpos, 2047);

    // Short mode for the reset and coincident-edge cases.
    g_len = 64; g_hs = 6; g_lines = 8; g_vs = 2; g_off = 20;
    g_hold = 1'b0;
    wait_vr(5, 4000);
    repeat (3) @(negedge clk);
    check_eq("small_lock", locked, 1);
    check_eq("small_h_total", h_total, 64);
    check_eq("small_v_total", v_total, 8);

    // Asynchronous reset mid-line while locked.
    wait_pos(5, 30, 2000);
    #1 reset = 1'b1;
    #1;
    check_eq("arst_hpos", hpos, 0);
    check_eq("arst_vpos", vpos, 0);
    check_eq("arst_h_total", h_total, 0);
    check_eq("arst_h_sync_w", h_sync_w, 0);
    check_eq("arst_v_total", v_total, 0);
    check_eq("arst_v_sync_w", v_sync_w, 0);
    check_eq("arst_locked", locked, 0);
    repeat (3) @(negedge clk);
    #1 reset = 1'b0;
    wait_vr(4, 4000);
    repeat (3) @(negedge clk);
    check_eq("arst_no_early_lock", locked, 0);
    wait_vr(1, 2000);
    repeat (3) @(negedge clk);
    check_eq("arst_relock", locked, 1);

    // vsync and hsync rising together: that hsync edge is not counted.
    wait_pos(4, -1, 2000);
    g_off = 0;
    wait_vr(1, 2000);
    check_eq("coinc_vpos", vpos, 0);
    check_eq("coinc_hpos", hpos, 0);
    wait_vr(1, 2000);
    check_eq("coinc_hpos2", hpos, 0);
    check_eq("coinc_v_total", v_total, 7);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
